// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with HI/LO registers for the MIPS datapath.
// Handles R-type mult, multu, div, divu, mthi and mtlo through a start/busy/done handshake.
// Optional feature macro MDU_DIV_EN: when defined, the restoring divider is compiled in;
// when undefined, div/divu complete after one busy cycle and leave HI/LO unchanged.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    typedef enum logic [1:0] {FIX_MULT, FIX_DIV, FIX_RAW, FIX_NONE} fix_t;

    state_t           state_q, state_d;
    fix_t             fix_q, fix_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             neg_res_q, neg_res_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Instruction decode, only meaningful while the unit is idle and not being flushed
    logic accept, is_signed, is_mult, is_div, is_mthi, is_mtlo;
    assign accept    = start && (state_q == IDLE) && !flush && (OpCode == 6'h00);
    assign is_signed = ~Funct[0];
    assign is_mult   = accept && ((Funct == 6'h18) || (Funct == 6'h19));
    assign is_div    = accept && ((Funct == 6'h1a) || (Funct == 6'h1b));
    assign is_mthi   = accept && (Funct == 6'h11);
    assign is_mtlo   = accept && (Funct == 6'h13);

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which fits unsigned
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             a_neg, b_neg;
    assign a_neg = is_signed && a[WIDTH-1];
    assign b_neg = is_signed && b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Shift-add step: conditionally add the multiplicand into the upper half, then shift right
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod, prod_fix;
    assign sum      = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : '0);
    assign prod     = {acc_q, mq_q};
    assign prod_fix = neg_res_q ? -prod : prod;

`ifdef MDU_DIV_EN
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff, quo_fix, rem_fix;
    logic             ge;
    // Restoring step: shift the next dividend bit into the remainder and try the subtraction
    assign shifted = {acc_q, mq_q[WIDTH-1]};
    assign ge      = shifted >= {1'b0, mcand_q};
    assign diff    = shifted[WIDTH-1:0] - mcand_q;
    assign quo_fix = neg_res_q ? -mq_q : mq_q;
    assign rem_fix = neg_rem_q ? -acc_q : acc_q;
`endif

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            fix_q     <= FIX_NONE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            mcand_q   <= '0;
            neg_res_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MDU_DIV_EN
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            fix_q     <= fix_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            mcand_q   <= mcand_d;
            neg_res_q <= neg_res_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MDU_DIV_EN
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    // Next-state logic: divide by zero (or a disabled divider) skips straight to FIX
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (is_mult) begin
                    state_d = CALC;
                end else if (is_div) begin
`ifdef MDU_DIV_EN
                    state_d = (b == '0) ? FIX : CALC;
`else
                    state_d = FIX;
`endif
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output logic: operand latching, one iteration per CALC cycle, HI/LO writeback in FIX
    always_comb begin
        fix_d     = fix_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        mcand_d   = mcand_q;
        neg_res_d = neg_res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        busy_d    = (state_d != IDLE);
`ifdef MDU_DIV_EN
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (is_mthi) hi_d = a;
                if (is_mtlo) lo_d = a;
                if (is_mult) begin
                    mcand_d   = a_mag;
                    mq_d      = b_mag;
                    acc_d     = '0;
                    cnt_d     = '0;
                    neg_res_d = a_neg ^ b_neg;
                    fix_d     = FIX_MULT;
                end
                if (is_div) begin
`ifdef MDU_DIV_EN
                    if (b == '0) begin
                        acc_d = a;
                        mq_d  = '1;
                        fix_d = FIX_RAW;
                    end else begin
                        mcand_d   = b_mag;
                        mq_d      = a_mag;
                        acc_d     = '0;
                        cnt_d     = '0;
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        fix_d     = FIX_DIV;
                    end
`else
                    fix_d = FIX_NONE;
`endif
                end
            end
            CALC: begin
                if (!flush) begin
                    cnt_d = cnt_q + CW'(1);
                    if (fix_q == FIX_MULT) begin
                        acc_d = sum[WIDTH:1];
                        mq_d  = {sum[0], mq_q[WIDTH-1:1]};
                    end
`ifdef MDU_DIV_EN
                    else begin
                        acc_d = ge ? diff : shifted[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], ge};
                    end
`endif
                end
            end
            FIX: begin
                if (!flush) begin
                    done_d = 1'b1;
                    case (fix_q)
                        FIX_MULT: begin
                            hi_d = prod_fix[2*WIDTH-1:WIDTH];
                            lo_d = prod_fix[WIDTH-1:0];
                        end
`ifdef MDU_DIV_EN
                        FIX_DIV: begin
                            hi_d = rem_fix;
                            lo_d = quo_fix;
                        end
                        FIX_RAW: begin
                            hi_d = acc_q;
                            lo_d = mq_q;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit at WIDTH=32; divide expectations follow MDU_DIV_EN.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [5:0]  OpCode = 6'h00;
    logic [5:0]  Funct = 6'h00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int passed = 0;
    int total = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush),
        .OpCode(OpCode), .Funct(Funct), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    // Free-running clock; inputs change and outputs are sampled on the falling edge
    always #5 clk = ~clk;

    // Issue one instruction, then count edges until done; lat=-1 means done never came
    task automatic run_op(input logic [5:0] fn, input logic [31:0] av, input logic [31:0] bv,
                          output int lat, output int busy_n);
        @(negedge clk);
        start = 1'b1; OpCode = 6'h00; Funct = fn; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        busy_n = busy ? 1 : 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %0b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("[TB] FAIL reset_done got %0b want 0", done); else passed++;
        total++; if (hi !== 32'h0) $display("[TB] FAIL reset_hi got %h want 0", hi); else passed++;
        total++; if (lo !== 32'h0) $display("[TB] FAIL reset_lo got %h want 0", lo); else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_multu();
        int lat, bn;
        run_op(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bn);
        total++; if (lat !== 33) $display("[TB] FAIL multu_latency got %0d want 33", lat); else passed++;
        total++; if (bn !== 33) $display("[TB] FAIL multu_busy_cycles got %0d want 33", bn); else passed++;
        total++; if (hi !== 32'hFFFFFFFE) $display("[TB] FAIL multu_hi got %h want fffffffe", hi); else passed++;
        total++; if (lo !== 32'h00000001) $display("[TB] FAIL multu_lo got %h want 00000001", lo); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL multu_busy_at_done got %0b want 0", busy); else passed++;
        @(negedge clk);
        total++; if (done !== 1'b0) $display("[TB] FAIL multu_done_width got %0b want 0", done); else passed++;
    endtask

    task automatic test_mult();
        int lat, bn;
        run_op(6'h18, 32'hFFFFFFFD, 32'd7, lat, bn);
        total++; if (lat !== 33) $display("[TB] FAIL mult_neg_latency got %0d want 33", lat); else passed++;
        total++; if (hi !== 32'hFFFFFFFF) $display("[TB] FAIL mult_neg_hi got %h want ffffffff", hi); else passed++;
        total++; if (lo !== 32'hFFFFFFEB) $display("[TB] FAIL mult_neg_lo got %h want ffffffeb", lo); else passed++;
        run_op(6'h18, 32'h80000000, 32'h80000000, lat, bn);
        total++; if (hi !== 32'h40000000) $display("[TB] FAIL mult_min_hi got %h want 40000000", hi); else passed++;
        total++; if (lo !== 32'h00000000) $display("[TB] FAIL mult_min_lo got %h want 0", lo); else passed++;
    endtask

    task automatic test_div();
        int lat, bn;
`ifdef MDU_DIV_EN
        run_op(6'h1a, 32'hFFFFFFF9, 32'd2, lat, bn);
        total++; if (lat !== 33) $display("[TB] FAIL div_neg_latency got %0d want 33", lat); else passed++;
        total++; if (lo !== 32'hFFFFFFFD) $display("[TB] FAIL div_neg_lo got %h want fffffffd", lo); else passed++;
        total++; if (hi !== 32'hFFFFFFFF) $display("[TB] FAIL div_neg_hi got %h want ffffffff", hi); else passed++;
        run_op(6'h1b, 32'd7, 32'd2, lat, bn);
        total++; if (lo !== 32'd3) $display("[TB] FAIL divu_lo got %h want 3", lo); else passed++;
        total++; if (hi !== 32'd1) $display("[TB] FAIL divu_hi got %h want 1", hi); else passed++;
        run_op(6'h1a, 32'h80000000, 32'hFFFFFFFF, lat, bn);
        total++; if (lo !== 32'h80000000) $display("[TB] FAIL div_ovf_lo got %h want 80000000", lo); else passed++;
        total++; if (hi !== 32'h0) $display("[TB] FAIL div_ovf_hi got %h want 0", hi); else passed++;
        run_op(6'h1b, 32'd5, 32'd0, lat, bn);
        total++; if (lat !== 1) $display("[TB] FAIL div0_latency got %0d want 1", lat); else passed++;
        total++; if (bn !== 1) $display("[TB] FAIL div0_busy_cycles got %0d want 1", bn); else passed++;
        total++; if (lo !== 32'hFFFFFFFF) $display("[TB] FAIL div0_lo got %h want ffffffff", lo); else passed++;
        total++; if (hi !== 32'd5) $display("[TB] FAIL div0_hi got %h want 5", hi); else passed++;
`else
        run_op(6'h19, 32'd6, 32'd7, lat, bn);
        total++; if (lo !== 32'd42) $display("[TB] FAIL nodiv_setup_lo got %h want 2a", lo); else passed++;
        run_op(6'h1b, 32'd7, 32'd2, lat, bn);
        total++; if (lat !== 1) $display("[TB] FAIL nodiv_latency got %0d want 1", lat); else passed++;
        total++; if (bn !== 1) $display("[TB] FAIL nodiv_busy_cycles got %0d want 1", bn); else passed++;
        total++; if (hi !== 32'd0) $display("[TB] FAIL nodiv_hi got %h want 0", hi); else passed++;
        total++; if (lo !== 32'd42) $display("[TB] FAIL nodiv_lo got %h want 2a", lo); else passed++;
`endif
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        start = 1'b1; OpCode = 6'h00; Funct = 6'h11; a = 32'h1234;
        @(negedge clk);
        total++; if (hi !== 32'h1234) $display("[TB] FAIL mthi_hi got %h want 1234", hi); else passed++;
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL mthi_handshake got busy=%0b done=%0b want 0/0", busy, done); else passed++;
        Funct = 6'h13; a = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        total++; if (lo !== 32'h5678) $display("[TB] FAIL mtlo_lo got %h want 5678", lo); else passed++;
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL mtlo_handshake got busy=%0b done=%0b want 0/0", busy, done); else passed++;
    endtask

    task automatic test_bad_opcode();
        @(negedge clk);
        start = 1'b1; OpCode = 6'h08; Funct = 6'h18; a = 32'd3; b = 32'd4;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("[TB] FAIL badop_busy got %0b want 0", busy); else passed++;
        OpCode = 6'h00; Funct = 6'h10; a = 32'hAAAA;
        @(negedge clk);
        start = 1'b0;
        total++; if (hi !== 32'h1234 || lo !== 32'h5678) $display("[TB] FAIL badop_hilo got %h/%h want 1234/5678", hi, lo); else passed++;
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        start = 1'b1; OpCode = 6'h00; Funct = 6'h18; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; Funct = 6'h13; a = 32'hDEAD;
        @(negedge clk);
        start = 1'b0;
        total++; if (lo !== 32'h5678 || busy !== 1'b1) $display("[TB] FAIL busy_start_ignored got lo=%h busy=%0b want 5678/1", lo, busy); else passed++;
        lat = -1;
        for (int n = 4; n <= 100; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
        total++; if (lat !== 33) $display("[TB] FAIL ignore_latency got %0d want 33", lat); else passed++;
        total++; if (hi !== 32'd0 || lo !== 32'd15) $display("[TB] FAIL ignore_result got %h/%h want 0/f", hi, lo); else passed++;
    endtask

    task automatic test_flush();
        int saw_done;
        @(negedge clk);
        start = 1'b1; OpCode = 6'h00; Funct = 6'h19; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 9; n++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++; if (busy !== 1'b0) $display("[TB] FAIL flush_busy got %0b want 0", busy); else passed++;
        saw_done = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        total++; if (saw_done !== 0) $display("[TB] FAIL flush_no_done got %0d pulses want 0", saw_done); else passed++;
        total++; if (hi !== 32'd0 || lo !== 32'd15) $display("[TB] FAIL flush_hilo got %h/%h want 0/f", hi, lo); else passed++;
        start = 1'b1; flush = 1'b1; Funct = 6'h11; a = 32'hBEEF;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        total++; if (hi !== 32'd0 || busy !== 1'b0) $display("[TB] FAIL flush_beats_start got hi=%h busy=%0b want 0/0", hi, busy); else passed++;
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        run_op(6'h18, 32'd2, 32'd3, lat, bn);
        total++; if (lo !== 32'd6 || lat !== 33) $display("[TB] FAIL b2b_first got lo=%h lat=%0d want 6/33", lo, lat); else passed++;
        start = 1'b1; OpCode = 6'h00; Funct = 6'h19; a = 32'd4; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b1) $display("[TB] FAIL b2b_accept_in_done got busy=%0b want 1", busy); else passed++;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
        total++; if (lat !== 33) $display("[TB] FAIL b2b_latency got %0d want 33", lat); else passed++;
        total++; if (hi !== 32'd0 || lo !== 32'd20) $display("[TB] FAIL b2b_result got %h/%h want 0/14", hi, lo); else passed++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; OpCode = 6'h00; Funct = 6'h19; a = 32'hFFFFFFFF; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 5; n++) @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (hi !== 32'd0 || lo !== 32'd0) $display("[TB] FAIL midreset_hilo got %h/%h want 0/0", hi, lo); else passed++;
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL midreset_handshake got busy=%0b done=%0b want 0/0", busy, done); else passed++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("[TB] FAIL midreset_stays_idle got %0b want 0", busy); else passed++;
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_bad_opcode();
        test_ignore_start();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Parametrised, multi-cycle multiply/divide unit with HI/LO registers for the MIPS datapath.
- Sits beside the ALU and decodes the same OpCode/Funct fields: R-type mult, multu, div, divu, mthi, mtlo.
- Multiply is iterative shift-add; divide is iterative restoring division on magnitudes.
- A start/busy/done handshake lets the controller stall until the result lands in HI/LO.

## Interface
Parameters:
- WIDTH, 32, operand width; even, >= 4. Iteration counter width is derived as $clog2(WIDTH+1).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- flush  input  1  synchronous abort of an in-flight operation
- OpCode  input  6  instruction opcode; must be 6'h00 for any action
- Funct  input  6  instruction funct
- a  input  WIDTH  rs operand (multiplicand / dividend / mthi-mtlo source)
- b  input  WIDTH  rt operand (multiplier / divisor)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO have just been written by mult/div
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

## Operation
- Decode, used only when start=1, busy=0, flush=0 and OpCode=6'h00:
  - 0x18 mult: signed multiply
  - 0x19 multu: unsigned multiply
  - 0x1a div: signed divide
  - 0x1b divu: unsigned divide
  - 0x11 mthi: HI<=a
  - 0x13 mtlo: LO<=a
  - Any other OpCode/Funct, including mfhi 0x10 and mflo 0x12: no state change.
- States: IDLE, CALC, FIX.
  - IDLE->CALC on an accepted mult/div. a and b are latched; for signed ops their magnitudes are latched along with the result signs.
  - CALC runs exactly WIDTH iterations, one result bit per cycle.
  - FIX applies sign correction, writes HI/LO, pulses done, returns to IDLE.
- Multiply: {hi,lo} = full 2*WIDTH-bit product; signed product is two's complement.
- Divide: lo = quotient, hi = remainder.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Signed overflow, min/-1: lo = min (wraps), hi = 0.
- Divide by zero is detected at accept and skips CALC. Result: lo = all ones, hi = a (raw operand), regardless of signedness.
- mthi/mtlo write at the next edge; busy and done stay 0.
- start while busy=1 is ignored; no queueing.
- flush:
  - In CALC/FIX: return to IDLE at the next edge; hi/lo unchanged; no done.
  - Beats start in the same cycle.
  - In IDLE: no effect.
- reset, at any time including mid-operation: state IDLE, busy=0, done=0, hi=0, lo=0.

## Timing
- Let E0 be the edge that accepts a mult/div.
- busy=1 from E0 through E(WIDTH+1).
- hi/lo update at E(WIDTH+1). At that same edge busy falls and done rises for exactly one cycle.
- Total latency is WIDTH+1 cycles for all mult/div operands except divide by zero.
- Divide by zero: busy=1 for one cycle; hi/lo written and done pulsed at E1.
- A new start is accepted in the cycle where done=1, since busy=0.
- mthi/mtlo: hi or lo valid after E0.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- MDU_DIV_EN
  - Defined: divider datapath is compiled in and behaves as above.
  - Undefined: divider logic is removed.
    - div/divu are still accepted: busy=1 for one cycle, done pulses at E1, hi/lo unchanged.
    - This way the controller never deadlocks.
    - mult, multu, mthi and mtlo are unaffected.

## Test plan
- WIDTH=32, multu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 cycles after E0; busy high 33 cycles.
- mult a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. mult a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0.
- div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 -> lo=3, hi=1. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu 5/0 -> lo=0xFFFFFFFF, hi=5, done at E1. Without MDU_DIV_EN, divu 7/2 -> done at E1, hi/lo unchanged.
- Abort and reset:
  - Start mult, assert start again at cycle 3 -> ignored.
  - flush at cycle 10 -> busy=0 next edge, no done, hi/lo retain previous values.
  - reset asserted mid-CALC -> hi=lo=0, busy=0 immediately.
- mthi a=0x1234 then mtlo a=0x5678 on consecutive cycles -> hi=0x1234 after E0, lo=0x5678 after E1; busy and done never assert.
- start with OpCode=0x08 and Funct=0x18 -> no change.
